// File: rtl/point_op_seq.sv
// Twisted-Edwards add/sub/double sequencer driving an external field unit over req/ack.
// Latency 1 + sum(L_k+1) cycles; holds fu_req and operands until fu_ack, ignores en while busy.
module point_op_seq #(
  parameter int N = 255,
  parameter logic [N-1:0] D2 = 255'h2406d9dc_56dffce7_198e80f2_eef3d130_00e0149a_8283b156_ebd69b94_26b2f159
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [N-1:0] x1, y1, z1, t1,
  input  logic [N-1:0] x2, y2, z2, t2,
  output logic [N-1:0] x3, y3, z3, t3,
  output logic         busy,
  output logic         data_rdy,
  output logic         fu_req,
  output logic [1:0]   fu_op,
  output logic [N-1:0] fu_a, fu_b,
  input  logic         fu_ack,
  input  logic [N-1:0] fu_res
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] OP_MUL = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2;
  localparam logic [1:0] M_ADD = 2'd0, M_SUB = 2'd1, M_DBL = 2'd2, M_RSV = 2'd3;
  localparam int NREG = 19;

  localparam logic [4:0] R_ZERO = 5'd0,  R_X1 = 5'd1,  R_Y1 = 5'd2,  R_Z1 = 5'd3,
                         R_T1   = 5'd4,  R_X2 = 5'd5,  R_Y2 = 5'd6,  R_Z2 = 5'd7,
                         R_T2   = 5'd8,  R_T0 = 5'd9,  R_TT = 5'd10, R_A  = 5'd11,
                         R_B    = 5'd12, R_C  = 5'd13, R_D  = 5'd14, R_E  = 5'd15,
                         R_F    = 5'd16, R_G  = 5'd17, R_H  = 5'd18, R_D2 = 5'd19;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] d;
  } uop_t;

  function automatic uop_t mk(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] d);
    return {op, a, b, d};
  endfunction

  // Final products land in A/B/C/D (X3/Y3/T3/Z3), which are dead by then.
  function automatic uop_t tail_uop(input logic [4:0] j);
    case (j)
      5'd0:    return mk(OP_MUL, R_E, R_F, R_A);
      5'd1:    return mk(OP_MUL, R_G, R_H, R_B);
      5'd2:    return mk(OP_MUL, R_E, R_H, R_C);
      default: return mk(OP_MUL, R_F, R_G, R_D);
    endcase
  endfunction

  function automatic uop_t add_uop(input logic [4:0] k);
    case (k)
      5'd0:    return mk(OP_SUB, R_Y1, R_X1, R_T0);
      5'd1:    return mk(OP_SUB, R_Y2, R_X2, R_TT);
      5'd2:    return mk(OP_MUL, R_T0, R_TT, R_A);
      5'd3:    return mk(OP_ADD, R_Y1, R_X1, R_T0);
      5'd4:    return mk(OP_ADD, R_Y2, R_X2, R_TT);
      5'd5:    return mk(OP_MUL, R_T0, R_TT, R_B);
      5'd6:    return mk(OP_MUL, R_T1, R_T2, R_T0);
      5'd7:    return mk(OP_MUL, R_T0, R_D2, R_C);
      5'd8:    return mk(OP_MUL, R_Z1, R_Z2, R_T0);
      5'd9:    return mk(OP_ADD, R_T0, R_T0, R_D);
      5'd10:   return mk(OP_SUB, R_B,  R_A,  R_E);
      5'd11:   return mk(OP_SUB, R_D,  R_C,  R_F);
      5'd12:   return mk(OP_ADD, R_D,  R_C,  R_G);
      5'd13:   return mk(OP_ADD, R_B,  R_A,  R_H);
      default: return tail_uop(k - 5'd14);
    endcase
  endfunction

  function automatic uop_t dbl_uop(input logic [4:0] k);
    case (k)
      5'd0:    return mk(OP_MUL, R_X1, R_X1, R_A);
      5'd1:    return mk(OP_MUL, R_Y1, R_Y1, R_B);
      5'd2:    return mk(OP_MUL, R_Z1, R_Z1, R_T0);
      5'd3:    return mk(OP_ADD, R_T0, R_T0, R_C);
      5'd4:    return mk(OP_ADD, R_A,  R_B,  R_H);
      5'd5:    return mk(OP_ADD, R_X1, R_Y1, R_T0);
      5'd6:    return mk(OP_MUL, R_T0, R_T0, R_TT);
      5'd7:    return mk(OP_SUB, R_H,  R_TT, R_E);
      5'd8:    return mk(OP_SUB, R_A,  R_B,  R_G);
      5'd9:    return mk(OP_ADD, R_C,  R_G,  R_F);
      default: return tail_uop(k - 5'd10);
    endcase
  endfunction

  state_t       state, state_d;
  logic [1:0]   mode_q;
  logic [4:0]   k, last_k;
  logic [N-1:0] rf [0:NREG-1];
  uop_t         uop;
  logic [N-1:0] opa, opb;
  logic         start, take;

  assign start = (state == IDLE) && en && (mode != M_RSV);
  assign take  = (state == WAIT) && fu_ack;

  always_comb begin
    uop    = add_uop(k);
    last_k = 5'd17;
    case (mode_q)
      M_SUB: begin
        last_k = 5'd19;
        if (k == 5'd0)      uop = mk(OP_SUB, R_ZERO, R_X2, R_X2);
        else if (k == 5'd1) uop = mk(OP_SUB, R_ZERO, R_T2, R_T2);
        else                uop = add_uop(k - 5'd2);
      end
      M_DBL: begin
        last_k = 5'd13;
        uop    = dbl_uop(k);
      end
      default: ;
    endcase
  end

  always_comb begin
    opa = '0;
    opb = '0;
    if (uop.a == R_D2)    opa = D2;
    else if (uop.a <= R_H) opa = rf[uop.a];
    if (uop.b == R_D2)    opb = D2;
    else if (uop.b <= R_H) opb = rf[uop.b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    busy     = 1'b0;
    data_rdy = 1'b0;
    fu_req   = 1'b0;
    fu_op    = OP_MUL;
    fu_a     = '0;
    fu_b     = '0;
    case (state)
      IDLE: if (start) state_d = ISSUE;
      ISSUE: begin
        busy    = 1'b1;
        fu_req  = 1'b1;
        fu_op   = uop.op;
        fu_a    = opa;
        fu_b    = opb;
        state_d = WAIT;
      end
      WAIT: begin
        busy   = 1'b1;
        fu_req = 1'b1;
        fu_op  = uop.op;
        fu_a   = opa;
        fu_b   = opb;
        if (fu_ack) state_d = (k == last_k) ? DONE : ISSUE;
      end
      DONE: begin
        busy     = 1'b1;
        data_rdy = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_ADD;
      k      <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      x3 <= '0;
      y3 <= '0;
      z3 <= '0;
      t3 <= '0;
    end else if (start) begin
      mode_q <= mode;
      k      <= '0;
      rf[R_X1] <= x1;
      rf[R_Y1] <= y1;
      rf[R_Z1] <= z1;
      rf[R_T1] <= t1;
      rf[R_X2] <= x2;
      rf[R_Y2] <= y2;
      rf[R_Z2] <= z2;
      rf[R_T2] <= t2;
    end else if (take) begin
      rf[uop.d] <= fu_res;
      k         <= k + 5'd1;
      // Last op produces Z3, so take it straight from the bus to have all four valid in DONE.
      if (k == last_k) begin
        x3 <= rf[R_A];
        y3 <= rf[R_B];
        t3 <= rf[R_C];
        z3 <= fu_res;
      end
    end
  end

endmodule

// File: tb/tb_point_op_seq.sv
// Bench for point_op_seq: modular field-unit model with programmable ack latency, directed vectors.
module tb_point_op_seq;

  localparam int N = 255;
  localparam logic [255:0] PM = (256'd1 << 255) - 256'd19;
  localparam logic [N-1:0] GX  = 255'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
  localparam logic [N-1:0] GY  = 255'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;
  localparam logic [N-1:0] AX2 = 255'h36ab384c_9f5a046c_3d043b7d_1833e7ac_080d8e45_15d7a45f_83c5a14e_2843ce0e;
  localparam logic [N-1:0] AY2 = 255'h2260cdf3_092329c2_1da25ee8_c9a21f56_97390f51_64385156_0e5f46ae_6af8a3c9;
  localparam logic [1:0] ADD_OPS [0:17] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0,
                                            2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [1:0] DBL_OPS [0:13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0,
                                            2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};

  typedef struct packed {
    logic [N-1:0] x, y, z, t;
  } pt_t;

  typedef struct {
    logic [1:0] m;
    pt_t        p;
    pt_t        q;
    int         kind;   // 0 exact, 1 affine 2G, 2 projective identity
    pt_t        e;
    int         cyc;
    int         hs;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, en;
  logic [1:0]   mode;
  logic [N-1:0] x1, y1, z1, t1, x2, y2, z2, t2;
  logic [N-1:0] x3, y3, z3, t3;
  logic         busy, data_rdy, fu_req, fu_ack;
  logic [1:0]   fu_op;
  logic [N-1:0] fu_a, fu_b, fu_res;

  logic         m_ack = 1'b0, stray_ack, lat_rand;
  logic [N-1:0] m_res = '0, stray_res;
  logic         pending = 1'b0;
  int           cnt = 0;
  logic [1:0]   c_op;
  logic [N-1:0] c_a, c_b;
  logic [1:0]   op_log [$];
  int           stab_err = 0;
  int           total = 0, bad = 0;

  assign fu_ack = m_ack | stray_ack;
  assign fu_res = stray_ack ? stray_res : m_res;

  always #5 clk = ~clk;

  point_op_seq dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .x1(x1), .y1(y1), .z1(z1), .t1(t1), .x2(x2), .y2(y2), .z2(z2), .t2(t2),
    .x3(x3), .y3(y3), .z3(z3), .t3(t3),
    .busy(busy), .data_rdy(data_rdy),
    .fu_req(fu_req), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b),
    .fu_ack(fu_ack), .fu_res(fu_res)
  );

  function automatic logic [N-1:0] fmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] pr, pw;
    pr = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    pw = '0;
    pw[255:0] = PM;
    pr = pr % pw;
    return pr[N-1:0];
  endfunction

  function automatic logic [N-1:0] fadd(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= PM) s = s - PM;
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] fsub(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + PM - {1'b0, b};
    if (s >= PM) s = s - PM;
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[N-33:0], $urandom};
    return r;
  endfunction

  function automatic pt_t mkpt(input logic [N-1:0] x, input logic [N-1:0] y,
                               input logic [N-1:0] z, input logic [N-1:0] t);
    pt_t p;
    p.x = x; p.y = y; p.z = z; p.t = t;
    return p;
  endfunction

  function automatic logic [1:0] exp_op(input logic [1:0] m, input int i);
    int j;
    if (m == 2'd2) return (i < 14) ? DBL_OPS[i] : 2'd3;
    j = i;
    if (m == 2'd1) begin
      if (j < 2) return 2'd2;
      j = j - 2;
    end
    return (j < 18) ? ADD_OPS[j] : 2'd3;
  endfunction

  // Field unit: ack L cycles after a request is seen, operands must stay put meanwhile.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack   = 1'b0;
      pending = 1'b0;
    end else begin
      if (m_ack) begin
        m_ack   = 1'b0;
        pending = 1'b0;
      end
      if (pending) begin
        if (fu_req !== 1'b1 || fu_op !== c_op || fu_a !== c_a || fu_b !== c_b) stab_err++;
        cnt--;
        if (cnt == 0) begin
          m_ack = 1'b1;
          case (c_op)
            2'd0:    m_res = fmul(c_a, c_b);
            2'd1:    m_res = fadd(c_a, c_b);
            2'd2:    m_res = fsub(c_a, c_b);
            default: m_res = '0;
          endcase
        end
      end else if (fu_req === 1'b1) begin
        c_op = fu_op;
        c_a  = fu_a;
        c_b  = fu_b;
        op_log.push_back(fu_op);
        pending = 1'b1;
        cnt = lat_rand ? int'($urandom_range(20, 1)) : 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_t(input string nm, input bit cond);
    total++;
    if (!cond) begin
      bad++;
      $display("FAIL %s: actual=0 required=1", nm);
    end
  endtask

  task automatic set_pts(input pt_t p, input pt_t q);
    x1 = p.x; y1 = p.y; z1 = p.z; t1 = p.t;
    x2 = q.x; y2 = q.y; z2 = q.z; t2 = q.t;
  endtask

  task automatic run_vec(input logic [1:0] m, input pt_t p, input pt_t q, input bit noise,
                         output int cyc);
    int gap;
    @(negedge clk);
    mode = m;
    set_pts(p, q);
    en = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    cyc = 1;
    gap = 0;
    if (noise) set_pts(mkpt(rnd(), rnd(), rnd(), rnd()), mkpt(rnd(), rnd(), rnd(), rnd()));
    while (data_rdy !== 1'b1 && cyc < 3000) begin
      if (busy !== 1'b1) gap++;
      en   = noise && (cyc % 7 == 3);
      mode = noise ? 2'd2 : m;
      @(negedge clk);
      cyc++;
    end
    if (busy !== 1'b1) gap++;
    chk_t("data_rdy_seen", data_rdy === 1'b1);
    chk_i("busy_gap", gap, 0);
    en   = noise;
    mode = 2'd0;
    @(negedge clk);
    en = 1'b0;
    chk_t("idle_after_rdy", data_rdy === 1'b0 && busy === 1'b0);
  endtask

  task automatic check_res(input string nm, input int kind, input pt_t e);
    case (kind)
      0: begin
        chk({nm, "_x3"}, x3, e.x);
        chk({nm, "_y3"}, y3, e.y);
        chk({nm, "_z3"}, z3, e.z);
        chk({nm, "_t3"}, t3, e.t);
      end
      1: begin
        chk({nm, "_aff_x"}, x3, fmul(AX2, z3));
        chk({nm, "_aff_y"}, y3, fmul(AY2, z3));
        chk({nm, "_ext_t"}, fmul(t3, z3), fmul(x3, y3));
        chk_t({nm, "_z_nz"}, z3 != '0);
      end
      default: begin
        chk({nm, "_x3"}, x3, '0);
        chk({nm, "_t3"}, t3, '0);
        chk({nm, "_y_eq_z"}, y3, z3);
        chk_t({nm, "_z_nz"}, z3 != '0);
      end
    endcase
  endtask

  initial begin
    vec_t vecs [6];
    pt_t  idp, gp, ref2g;
    int   cyc, base, mism, guard, ign;
    logic [N-1:0] pm1;

    rst_n = 1'b0; en = 1'b0; mode = 2'd0; lat_rand = 1'b0;
    stray_ack = 1'b0; stray_res = '0;
    x1 = '0; y1 = '0; z1 = '0; t1 = '0; x2 = '0; y2 = '0; z2 = '0; t2 = '0;

    idp = mkpt('0, 255'd1, 255'd1, '0);
    gp  = mkpt(GX, GY, 255'd1, fmul(GX, GY));
    pm1 = PM[N-1:0] - 255'd1;
    vecs[0] = '{m: 2'd0, p: idp, q: idp, kind: 0, e: mkpt('0, 255'd4, 255'd4, '0), cyc: 37, hs: 18};
    vecs[1] = '{m: 2'd2, p: idp, q: idp, kind: 0, e: mkpt('0, pm1, pm1, '0),       cyc: 29, hs: 14};
    vecs[2] = '{m: 2'd1, p: idp, q: idp, kind: 0, e: mkpt('0, 255'd4, 255'd4, '0), cyc: 41, hs: 20};
    vecs[3] = '{m: 2'd0, p: gp,  q: gp,  kind: 1, e: idp, cyc: 37, hs: 18};
    vecs[4] = '{m: 2'd2, p: gp,  q: idp, kind: 1, e: idp, cyc: 29, hs: 14};
    vecs[5] = '{m: 2'd1, p: gp,  q: gp,  kind: 2, e: idp, cyc: 41, hs: 20};
    ref2g = idp;

    repeat (2) @(negedge clk);
    chk("rst_x3", x3, '0);
    chk("rst_y3", y3, '0);
    chk("rst_z3", z3, '0);
    chk("rst_t3", t3, '0);
    chk_t("rst_ctl", busy === 1'b0 && data_rdy === 1'b0 && fu_req === 1'b0 && fu_op === 2'd0);
    chk("rst_fu_a", fu_a, '0);
    chk("rst_fu_b", fu_b, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      base = op_log.size();
      run_vec(vecs[i].m, vecs[i].p, vecs[i].q, 1'b0, cyc);
      chk_i($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      chk_i($sformatf("v%0d_handshakes", i), op_log.size() - base, vecs[i].hs);
      mism = 0;
      for (int j = base; j < op_log.size(); j++)
        if (op_log[j] !== exp_op(vecs[i].m, j - base)) mism++;
      chk_i($sformatf("v%0d_op_order", i), mism, 0);
      check_res($sformatf("v%0d", i), vecs[i].kind, vecs[i].e);
      if (i == 3) ref2g = mkpt(x3, y3, z3, t3);
    end

    // Random ack latency, input churn and en pulses while busy.
    lat_rand = 1'b1;
    base = op_log.size();
    run_vec(2'd0, gp, gp, 1'b1, cyc);
    chk_i("rand_add_handshakes", op_log.size() - base, 18);
    check_res("rand_add", 0, ref2g);
    run_vec(2'd2, gp, gp, 1'b1, cyc);
    check_res("rand_dbl", 1, idp);
    lat_rand = 1'b0;

    // Reserved mode must not start.
    @(negedge clk);
    set_pts(gp, gp);
    mode = 2'd3;
    en   = 1'b1;
    ign  = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || fu_req !== 1'b0 || data_rdy !== 1'b0) ign++;
    end
    en = 1'b0;
    chk_i("mode11_ignored", ign, 0);

    // Reset during op 7 of an add.
    @(negedge clk);
    mode = 2'd0;
    set_pts(gp, gp);
    base = op_log.size();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    guard = 0;
    while (op_log.size() - base < 8 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    #2;
    chk_t("reached_op7", op_log.size() - base == 8 && fu_req === 1'b1);
    rst_n = 1'b0;
    #1;
    chk_t("abort_ctl", busy === 1'b0 && data_rdy === 1'b0 && fu_req === 1'b0 && fu_op === 2'd0);
    chk("abort_fu_a", fu_a, '0);
    chk("abort_x3", x3, '0);
    chk("abort_z3", z3, '0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_res = rnd();
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    chk_t("stray_ack_ignored", busy === 1'b0 && fu_req === 1'b0 && data_rdy === 1'b0);
    chk("stray_x3", x3, '0);

    base = op_log.size();
    run_vec(2'd0, idp, idp, 1'b0, cyc);
    chk_i("post_rst_cycles", cyc, 37);
    chk_i("post_rst_handshakes", op_log.size() - base, 18);
    check_res("post_rst", 0, vecs[0].e);

    chk_i("operand_stability", stab_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
